// File: rtl/divider_unit_if.sv
// Request/response bundle between decode/issue and the divider unit.
// The master side (issue stage) presents operands and flush; the slave side
// (divider) answers with ready, done and the result word.
interface divider_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        word_i;
  logic        flush;
  logic        done_o;
  logic [63:0] result;

  modport master (
    output valid_i, a, b, op, word_i, flush,
    input  ready_o, done_o, result
  );

  modport slave (
    input  valid_i, a, b, op, word_i, flush,
    output ready_o, done_o, result
  );
endinterface

// File: rtl/divider_unit.sv
// divider_unit: 64-bit restoring divider for DIV/DIVU/REM/REMU and their
// W variants. One shift-subtract step per clock, 64 steps per operation.
// Signed operations divide magnitudes and restore the signs at the end.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// complete directly on the accept edge instead of running all 64 steps.
module divider_unit (
  input logic          clk,
  input logic          reset,
  divider_unit_if.slave bus
);

  typedef logic [63:0] word_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam word_t MOST_NEG = 64'h8000_0000_0000_0000;

  state_t state, state_next;

  logic [5:0] count;
  word_t      quot;
  word_t      rem;
  word_t      divisor;
  word_t      dividend;
  logic       is_rem;
  logic       is_word;
  logic       neg_q;
  logic       neg_r;
  logic       is_dbz;
  logic       is_ovf;
  word_t      result_q;

  logic       accept;
  logic       load_busy;
`ifdef DIV_FAST_PATH_EN
  logic       load_fast;
  word_t      final_fast;
`endif

  logic       signed_in;
  word_t      a_ext;
  word_t      b_ext;
  logic       a_neg;
  logic       b_neg;
  word_t      a_mag;
  word_t      b_mag;
  logic       dbz_in;
  logic       ovf_in;

  logic [64:0] shifted;
  logic [64:0] diff;
  word_t       rem_step;
  word_t       quot_step;
  word_t       final_busy;

  // Turns raw magnitudes into the architectural result: sign restore,
  // forced values for the two special cases, then word-mode sign extension.
  function automatic word_t finalize(
    input word_t q_mag,
    input word_t r_mag,
    input word_t dvd,
    input logic  rem_sel,
    input logic  word_sel,
    input logic  nq,
    input logic  nr,
    input logic  dbz,
    input logic  ovf
  );
    word_t q;
    word_t r;
    word_t raw;
    q = nq ? -q_mag : q_mag;
    r = nr ? -r_mag : r_mag;
    if (dbz) begin
      q = '1;
      r = dvd;
    end else if (ovf) begin
      q = dvd;
      r = '0;
    end
    raw = rem_sel ? r : q;
    if (word_sel) begin
      raw = {{32{raw[31]}}, raw[31:0]};
    end
    return raw;
  endfunction

  // Operand preparation: word-mode extension, sign detection, magnitudes
  // and special-case detection, all from the live request inputs.
  always_comb begin
    signed_in = ~bus.op[0];
    if (bus.word_i) begin
      a_ext = signed_in ? {{32{bus.a[31]}}, bus.a[31:0]} : {32'b0, bus.a[31:0]};
      b_ext = signed_in ? {{32{bus.b[31]}}, bus.b[31:0]} : {32'b0, bus.b[31:0]};
    end else begin
      a_ext = bus.a;
      b_ext = bus.b;
    end
    a_neg  = signed_in & a_ext[63];
    b_neg  = signed_in & b_ext[63];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    dbz_in = (b_ext == '0);
    ovf_in = signed_in && (a_ext == MOST_NEG) && (b_ext == '1);
  end

  // One restoring step: shift in the next dividend bit, try the subtract,
  // keep it only if it did not borrow.
  always_comb begin
    shifted    = {rem, quot[63]};
    diff       = shifted - {1'b0, divisor};
    rem_step   = diff[64] ? shifted[63:0] : diff[63:0];
    quot_step  = {quot[62:0], ~diff[64]};
    final_busy = finalize(quot_step, rem_step, dividend, is_rem, is_word,
                          neg_q, neg_r, is_dbz, is_ovf);
  end

`ifdef DIV_FAST_PATH_EN
  // Special-case result available straight from the request operands.
  always_comb begin
    final_fast = finalize('0, '0, a_ext, bus.op[1], bus.word_i,
                          1'b0, 1'b0, dbz_in, ovf_in);
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs; flush wins over everything.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_busy  = 1'b0;
`ifdef DIV_FAST_PATH_EN
    load_fast  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.valid_i && !bus.flush) begin
          accept     = 1'b1;
          state_next = BUSY;
`ifdef DIV_FAST_PATH_EN
          if (dbz_in || ovf_in) begin
            state_next = DONE;
            load_fast  = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (count == 6'd63) begin
          state_next = DONE;
          load_busy  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    bus.ready_o = (state == IDLE);
    bus.done_o  = (state == DONE) && !bus.flush;
  end

  // Datapath registers: latch operands on accept, iterate while busy,
  // capture the finished result when entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      dividend <= '0;
      is_rem   <= 1'b0;
      is_word  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_dbz   <= 1'b0;
      is_ovf   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        count    <= '0;
        quot     <= a_mag;
        rem      <= '0;
        divisor  <= b_mag;
        dividend <= a_ext;
        is_rem   <= bus.op[1];
        is_word  <= bus.word_i;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        is_dbz   <= dbz_in;
        is_ovf   <= ovf_in;
      end else if (state == BUSY) begin
        count <= count + 6'd1;
        quot  <= quot_step;
        rem   <= rem_step;
      end
      if (load_busy) begin
        result_q <= final_busy;
      end
`ifdef DIV_FAST_PATH_EN
      if (load_fast) begin
        result_q <= final_fast;
      end
`endif
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: scoreboard bench for divider_unit. Expected results and
// latencies are queued at the accept edge and checked when done_o pulses.
module tb_divider_unit;

  logic clk;
  logic reset;
  int   cycle;
  int   testsRun;
  int   testsFailed;

  logic [63:0] expQ[$];
  int          edgeQ[$];
  int          accQ[$];
  string       tagQ[$];

  divider_unit_if bus();

  divider_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurement.
  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  // Independent reference of the RISC-V division semantics.
  function automatic logic [63:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] op, input logic w);
    logic signed [31:0] sa32, sb32;
    logic        [31:0] ua32, ub32, r32;
    logic signed [63:0] sa64, sb64;
    logic        [63:0] r64;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = a[31:0]; sb32 = b[31:0];
    sa64 = a;       sb64 = b;
    if (w) begin
      if (ub32 == 32'h0) r32 = op[1] ? ua32 : 32'hFFFF_FFFF;
      else if (!op[0] && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF)
        r32 = op[1] ? 32'h0 : ua32;
      else begin
        case (op)
          2'd0:    r32 = sa32 / sb32;
          2'd1:    r32 = ua32 / ub32;
          2'd2:    r32 = sa32 % sb32;
          default: r32 = ua32 % ub32;
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'h0) r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = op[1] ? 64'h0 : a;
    else begin
      case (op)
        2'd0:    r64 = sa64 / sb64;
        2'd1:    r64 = a / b;
        2'd2:    r64 = sa64 % sb64;
        default: r64 = a % b;
      endcase
    end
    return r64;
  endfunction

  // Edges from accept to done_o for a request.
  function automatic int expEdges(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] op, input logic w);
    logic special;
    special = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    if (!w && !op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      special = 1'b1;
`ifdef DIV_FAST_PATH_EN
    return special ? 0 : 64;
`else
    return special ? 64 : 64;
`endif
  endfunction

  // Handshake one request; returns right after the accept edge and then
  // scrambles the operand inputs so late changes would corrupt a bad DUT.
  task automatic issueRequest(input logic [63:0] a, input logic [63:0] b,
                              input logic [1:0] op, input logic w);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) checkOutput("ready_timeout", 64'(bus.ready_o), 64'h1);
    bus.valid_i = 1'b1;
    bus.a       = a;
    bus.b       = b;
    bus.op      = op;
    bus.word_i  = w;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.a       = {$urandom, $urandom};
    bus.b       = {$urandom, $urandom};
    bus.op      = 2'($urandom_range(0, 3));
    bus.word_i  = 1'($urandom_range(0, 1));
  endtask

  // Drive a tracked request and wait (bounded) for its result to be checked.
  task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] op, input logic w, input logic [63:0] expected);
    issueRequest(a, b, op, w);
    expQ.push_back(expected);
    edgeQ.push_back(expEdges(a, b, op, w));
    accQ.push_back(cycle);
    tagQ.push_back(tag);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checkOutput({tag, "_timeout"}, 64'(expQ.size()), 64'h0);
      expQ.delete(); edgeQ.delete(); accQ.delete(); tagQ.delete();
    end
  endtask

  // Response monitor: every done_o pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (!reset && bus.done_o) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_done", 64'h1, 64'h0);
      end else begin
        automatic logic [63:0] e   = expQ.pop_front();
        automatic int          ed  = edgeQ.pop_front();
        automatic int          acc = accQ.pop_front();
        automatic string       t   = tagQ.pop_front();
        checkOutput({t, "_result"}, bus.result, e);
        checkOutput({t, "_latency"}, 64'(cycle - acc), 64'(ed));
        checkOutput({t, "_ready_in_done"}, 64'(bus.ready_o), 64'h0);
      end
    end
  end

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    logic        rw;
    cycle       = 0;
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.op      = '0;
    bus.word_i  = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 64'(bus.ready_o), 64'h1);
    checkOutput("reset_done", 64'(bus.done_o), 64'h0);
    checkOutput("reset_result", bus.result, 64'h0);
    reset = 1'b0;

    applyStimulus("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("divuw", 64'h1_FFFF_FFFF, 64'h1_0000_0002, 2'd1, 1'b1, 64'h0000_0000_7FFF_FFFF);
    applyStimulus("remw_m7_3", 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("div_by0", 64'd5, 64'd0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("remu_by0", 64'd5, 64'd0, 2'd3, 1'b0, 64'd5);
    applyStimulus("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0,
                  64'h8000_0000_0000_0000);
    applyStimulus("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0, 64'h0);
    applyStimulus("divw_ovf", 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b1,
                  64'hFFFF_FFFF_8000_0000);
    applyStimulus("remuw_by0", 64'h8000_0000, 64'h1_0000_0000, 2'd3, 1'b1, 64'hFFFF_FFFF_8000_0000);

    // Flush in the middle of an operation: no done, back to IDLE at once.
    issueRequest(64'd50, 64'd3, 2'd1, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_ready", 64'(bus.ready_o), 64'h1);
    checkOutput("flush_done", 64'(bus.done_o), 64'h0);
    repeat (70) @(negedge clk);
    applyStimulus("divu_100_7", 64'd100, 64'd7, 2'd1, 1'b0, 64'd14);

    // Asynchronous reset between edges while busy.
    issueRequest(64'd999, 64'd10, 2'd1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_ready", 64'(bus.ready_o), 64'h1);
    checkOutput("async_reset_done", 64'(bus.done_o), 64'h0);
    checkOutput("async_reset_result", bus.result, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("div_after_reset", 64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, 2'd0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FEB3);

    // Randomised mix checked against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra  = {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rb = 64'h0;
        1:       rb = 64'($urandom_range(1, 100));
        2:       rb = -64'($urandom_range(1, 100));
        default: rb = {$urandom, $urandom} >> $urandom_range(0, 60);
      endcase
      applyStimulus($sformatf("rand%0d", i), ra, rb, rop, rw, refModel(ra, rb, rop, rw));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
